// File: rtl/keccak_pkg.sv
// keccak_pkg: shared types and default geometry for the Keccak state loader.
// The default geometry is 64 slices of 25 bits, which gives the 1600-bit Keccak state.
package keccak_pkg;

  localparam int KECCAK_SLICE_W = 25;
  localparam int KECCAK_LANES   = 64;
  localparam int KECCAK_STATE_W = KECCAK_SLICE_W * KECCAK_LANES;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_state_t;

endpackage

// File: rtl/keccak_state_loader.sv
// keccak_state_loader: assembles DEPTH slice words into one state and hands it downstream.
// Define STATE_LOADER_PAD_EN to add the in_last port, which ends a frame early.
module keccak_state_loader
  import keccak_pkg::*;
#(
  parameter int WORD_W = KECCAK_SLICE_W,
  parameter int DEPTH  = KECCAK_LANES,
  localparam int STATE_W = WORD_W * DEPTH,
  localparam int CNT_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
`ifdef STATE_LOADER_PAD_EN
  input  logic               in_last,
`endif
  output logic               out_valid,
  output logic [STATE_W-1:0] out_data,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   word_cnt,
  output logic [15:0]        frame_cnt,
  output logic               dbg_state
);

  // Handshake: a transfer happens on a posedge where valid && ready. in_ready and
  // out_valid depend only on the state register. A producer holds its word until it is accepted.

  loader_state_t      state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic in_fire;
  logic out_fire;
  logic last_word;
  logic frame_done;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == FULL);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_word = (word_cnt_q == CNT_W'(DEPTH - 1));

`ifdef STATE_LOADER_PAD_EN
  // The register is zero at frame start, so the words after an early end read as zero.
  assign frame_done = last_word || in_last;
`else
  assign frame_done = last_word;
`endif

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    data_d      = data_q;
    frame_cnt_d = frame_cnt_q;

    if (flush) begin
      state_d    = FILL;
      word_cnt_d = '0;
      data_d     = '0;
    end else if (state_q == FILL) begin
      if (in_fire) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (word_cnt_q == CNT_W'(k)) begin
            data_d[k*WORD_W +: WORD_W] = in_data;
          end
        end
        if (frame_done) begin
          state_d    = FULL;
          word_cnt_d = '0;
        end else begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
        end
      end
    end else begin
      if (out_fire) begin
        state_d     = FILL;
        data_d      = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      word_cnt_q  <= '0;
      data_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_data  = data_q;
  assign word_cnt  = word_cnt_q;
  assign frame_cnt = frame_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keccak_state_loader.sv
// tb_keccak_state_loader: directed and randomized checks of keccak_state_loader against a word-queue model.
// The in_last scenario is built only when STATE_LOADER_PAD_EN is defined.
module tb_keccak_state_loader;

  localparam int W  = 25;
  localparam int D  = 64;
  localparam int SW = W * D;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
`ifdef STATE_LOADER_PAD_EN
  logic          in_last;
`endif
  logic          out_valid;
  logic [SW-1:0] out_data;
  logic          out_ready;
  logic [5:0]    word_cnt;
  logic [15:0]   frame_cnt;
  logic          dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [SW-1:0] exp_q[$];

  keccak_state_loader dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef STATE_LOADER_PAD_EN
    .in_last   (in_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .word_cnt  (word_cnt),
    .frame_cnt (frame_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] pack(input logic [W-1:0] w[$]);
    logic [SW-1:0] r;
    r = '0;
    foreach (w[i]) r[i*W +: W] = w[i];
    return r;
  endfunction

  function automatic int first_bad_word(input logic [SW-1:0] a, input logic [SW-1:0] b);
    for (int k = 0; k < D; k++) begin
      if (a[k*W +: W] !== b[k*W +: W]) return k;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef STATE_LOADER_PAD_EN
    in_last   = 1'b0;
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: nonzero, first word %0d", first_bad_word(out_data, '0)); end
    n_cmp++; if (word_cnt !== 6'd0) begin n_err++; $display("FAIL reset_word_cnt: got %0d want 0", word_cnt); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_fill();
    logic [W-1:0]  words[$];
    logic [SW-1:0] exp;
    for (int k = 0; k < D; k++) begin
      in_valid = 1'b1;
      in_data  = W'(k + 1);
      words.push_back(W'(k + 1));
      step();
      n_cmp++;
      if (out_valid !== (k == D - 1)) begin
        n_err++; $display("FAIL fill_out_valid word %0d: got %b want %b", k, out_valid, (k == D - 1));
      end
    end
    in_valid = 1'b0;
    exp = pack(words);
    n_cmp++; if (out_data[24:0] !== 25'd1) begin n_err++; $display("FAIL fill_low_word: got %0d want 1", out_data[24:0]); end
    n_cmp++; if (out_data[1599:1575] !== 25'd64) begin n_err++; $display("FAIL fill_top_word: got %0d want 64", out_data[1599:1575]); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (word_cnt !== 6'd0) begin n_err++; $display("FAIL fill_word_cnt: got %0d want 0", word_cnt); end
    n_cmp++;
    if (out_data !== exp) begin
      n_err++; $display("FAIL fill_frame: first bad word %0d got %h want %h", first_bad_word(out_data, exp),
                        out_data[first_bad_word(out_data, exp)*W +: W], exp[first_bad_word(out_data, exp)*W +: W]);
    end
    exp_q.push_back(exp);
  endtask

  task automatic test_hold();
    logic [SW-1:0] held;
    held = exp_q.pop_front();
    for (int c = 0; c < 10; c++) begin
      in_valid  = 1'b1;
      in_data   = W'($urandom);
      out_ready = 1'b0;
      step();
      n_cmp++; if (out_data !== held) begin n_err++; $display("FAIL hold_data cycle %0d: word %0d changed", c, first_bad_word(out_data, held)); end
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL hold_flags cycle %0d: in_ready %b out_valid %b want 0 1", c, in_ready, out_valid); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL hold_frame_cnt: got %0d want 1", frame_cnt); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL hold_cleared: word %0d nonzero", first_bad_word(out_data, '0)); end
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_flush_partial();
    logic [W-1:0]  words[$];
    logic [SW-1:0] exp;
    for (int k = 0; k < 30; k++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      step();
    end
    n_cmp++; if (word_cnt !== 6'd30) begin n_err++; $display("FAIL flush_pre_word_cnt: got %0d want 30", word_cnt); end
    flush    = 1'b1;
    in_data  = W'($urandom);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (word_cnt !== 6'd0) begin n_err++; $display("FAIL flush_word_cnt: got %0d want 0", word_cnt); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL flush_out_data: word %0d nonzero", first_bad_word(out_data, '0)); end
    n_cmp++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL flush_frame_cnt: got %0d want 1", frame_cnt); end
    for (int k = 0; k < D; k++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      words.push_back(in_data);
      step();
    end
    in_valid = 1'b0;
    exp = pack(words);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_refill_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== exp) begin n_err++; $display("FAIL flush_refill_frame: first bad word %0d", first_bad_word(out_data, exp)); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (frame_cnt !== 16'd2) begin n_err++; $display("FAIL flush_refill_count: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_flush_full();
    for (int k = 0; k < D; k++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL flushfull_pre_valid: got %b want 1", out_valid); end
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (frame_cnt !== 16'd2) begin n_err++; $display("FAIL flushfull_frame_cnt: got %0d want 2", frame_cnt); end
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flushfull_flags: out_valid %b in_ready %b want 0 1", out_valid, in_ready); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL flushfull_out_data: word %0d nonzero", first_bad_word(out_data, '0)); end
  endtask

`ifdef STATE_LOADER_PAD_EN
  task automatic test_pad();
    logic [SW-1:0] exp;
    logic [SW-1:0] one;
    one = 1;
    exp = (one << 75) - one;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 25'h1FFFFFF;
      in_last  = (k == 2);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pad_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== exp) begin n_err++; $display("FAIL pad_frame: first bad word %0d", first_bad_word(out_data, exp)); end
    n_cmp++; if (word_cnt !== 6'd0) begin n_err++; $display("FAIL pad_word_cnt: got %0d want 0", word_cnt); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (frame_cnt !== 16'd3) begin n_err++; $display("FAIL pad_frame_cnt: got %0d want 3", frame_cnt); end
  endtask
`endif

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom) | W'(1);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++; if (word_cnt !== 6'd0) begin n_err++; $display("FAIL async_word_cnt: got %0d want 0", word_cnt); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL async_out_data: word %0d nonzero", first_bad_word(out_data, '0)); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL async_frame_cnt: got %0d want 0", frame_cnt); end
    #1;
    rst = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic [W-1:0]  cur[$];
    logic [SW-1:0] exp;
    int frames_done;
    int cycles;
    logic acc;
    logic hs;
    int bad;
    exp_q.delete();
    idle_inputs();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
    frames_done = 0;
    cycles      = 0;
    acc         = 1'b0;
    while (frames_done < 100 && cycles < 60000) begin
      if (!(in_valid && !acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = W'($urandom);
      end
      out_ready = $urandom_range(0, 1) == 1;
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_unexpected_frame at cycle %0d", cycles);
        end else begin
          exp = exp_q.pop_front();
          bad = first_bad_word(out_data, exp);
          if (bad >= 0) begin
            n_err++; $display("FAIL rand_frame %0d: word %0d got %h want %h", frames_done, bad, out_data[bad*W +: W], exp[bad*W +: W]);
          end
        end
        frames_done++;
      end
      if (acc) begin
        cur.push_back(in_data);
        if (cur.size() == D) begin
          exp_q.push_back(pack(cur));
          cur.delete();
        end
      end
      step();
      cycles++;
      n_cmp++;
      if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() == 0)) begin
        n_err++; $display("FAIL rand_flags cycle %0d: out_valid %b in_ready %b pending %0d", cycles, out_valid, in_ready, exp_q.size());
      end
      n_cmp++;
      if (word_cnt !== 6'(cur.size())) begin
        n_err++; $display("FAIL rand_word_cnt cycle %0d: got %0d want %0d", cycles, word_cnt, cur.size());
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (frames_done < 100) begin
      n_err++; $display("FAIL rand_timeout: got %0d frames want 100 within 60000 cycles", frames_done);
    end
    n_cmp++; if (frame_cnt !== 16'd100) begin n_err++; $display("FAIL rand_frame_cnt: got %0d want 100", frame_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_flush_partial();
    test_flush_full();
`ifdef STATE_LOADER_PAD_EN
    test_pad();
`endif
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keccak_state_loader.md
# keccak_state_loader

Synthesizable serial-in/parallel-out loader for the Keccak permutation datapath. It accepts the state one slice-word per handshake and assembles a full state register, for example 64 words of 25 bits forming the 1600-bit state. It then presents the completed state to the downstream round or rotate stage with a valid/ready handshake. This block replaces file-based state injection, so the same loader works in simulation and in silicon.

## Interface
- `WORD_W`, 25: width of one input word, one 5x5 slice.
- `DEPTH`, 64: words per frame (lane length); legal range 2..64.
- `STATE_W`, `WORD_W*DEPTH`: output width; derived, not overridden.
- `CNT_W`, `$clog2(DEPTH)`: word counter width.
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous frame discard.
- `in_valid` input 1: producer has a word.
- `in_data` input `WORD_W`: slice word.
- `in_ready` output 1: loader accepts a word this cycle.
- `in_last` input 1: early end of frame; present only with `STATE_LOADER_PAD_EN`.
- `out_valid` output 1: `out_data` holds a complete frame.
- `out_data` output `STATE_W`: assembled state.
- `out_ready` input 1: consumer takes the frame.
- `word_cnt` output `CNT_W`: index of the next word to be written.
- `frame_cnt` output 16: completed frames consumed; wraps at 2^16.

## Operation
- FSM has two states: FILL and FULL. Reset state is FILL.
- FILL:
  - `in_ready`=1 and `out_valid`=0.
  - A word is accepted when `in_valid`&&`in_ready` at posedge.
  - Word k is written to `out_data[k*WORD_W +: WORD_W]`, so word 0 occupies the LSBs. Then `word_cnt` increments.
- Accepting word `DEPTH-1`: go to FULL, and `word_cnt` returns to 0.
- FULL:
  - `in_ready`=0 and `out_valid`=1.
  - `out_data` is stable until the frame is consumed.
  - On `out_valid`&&`out_ready`: go to FILL, clear `out_data` to 0, and increment `frame_cnt`.
- `flush`:
  - Takes priority over both handshakes.
  - Next state is FILL; `word_cnt`=0 and `out_data`=0.
  - `frame_cnt` is unchanged. A word offered in the same cycle is dropped.
  - In FULL, the held frame is discarded and not counted.
- `out_data` is meaningful only while `out_valid`=1. In FILL it shows the partial frame, with unwritten words at 0.
- Asserting `in_valid` while in FULL has no effect; the producer must hold the word.
- Asynchronous reset mid-frame discards everything. Outputs take reset values immediately.

## Timing
- Reset values:
  - `in_ready`=1 (FILL).
  - `out_valid`=0, `out_data`=0.
  - `word_cnt`=0, `frame_cnt`=0.
- `in_ready` and `out_valid` are decoded from the state register only. No combinational path exists from `out_ready` or `in_valid`.
- Latency: `out_valid` rises the cycle after the last word is accepted.
- Minimum frame period is DEPTH+1 cycles: DEPTH accept cycles, then one FULL cycle with `out_ready`=1.
- `in_ready` returns high the cycle after the output handshake.
- Back-to-back words are accepted every cycle in FILL.

## Configuration
- `STATE_LOADER_PAD_EN` defined:
  - Port `in_last` exists.
  - Accepting a word with `in_last`=1 at index k<DEPTH-1 completes the frame. Words k+1..DEPTH-1 read as zero, because the register was cleared at frame start. The FSM goes to FULL.
  - `in_last` on word `DEPTH-1` is redundant and harmless.
  - `in_last` without `in_valid` is ignored.
- Undefined: no `in_last` port; every frame is exactly DEPTH words.

## Structure
- `keccak_pkg` holds:
  - the FSM state enum `loader_state_t` {FILL, FULL};
  - the constants `KECCAK_SLICE_W`=25, `KECCAK_LANES`=64 and `KECCAK_STATE_W`=1600, used as parameter defaults.
- Flat single module; no sub-module. The counter and write decoder are local logic.

## Test plan
- Reset, then 64 words with word k = k+1 back-to-back, `out_ready`=0:
  - `out_valid`=1 exactly one cycle after word 63;
  - `out_data[24:0]`=1 and `out_data[1599:1575]`=64;
  - `in_ready`=0 while held.
- Hold in FULL for 10 cycles, then `out_ready`=1 for one cycle:
  - `out_data` is unchanged over the hold;
  - after the handshake, `frame_cnt`=1, `out_data`=0 and `in_ready`=1.
- `flush` after 30 words: `word_cnt`=0 and `out_data`=0; a following 64-word frame assembles correctly with no residue.
- `flush` in FULL coinciding with `out_ready`=1: the frame is dropped and `frame_cnt` is unchanged.
- With `STATE_LOADER_PAD_EN`: 3 words 25'h1FFFFFF, the third with `in_last` → FULL; `out_data[74:0]` is all ones and the upper bits are 0.
- Random `in_valid`/`out_ready` stalls over 100 frames: every frame matches the reference model and `frame_cnt`=100.
